// File: rtl/synapse_accum_if.sv
// Handshake and weight-write bundle between a timestep controller and synapse_accum.
// The controller side is the master; the accumulator is the slave.
interface synapse_accum_if #(
    parameter int N_IN   = 8,
    parameter int V_SIZE = 4,
    parameter int W_SIZE = 4
) ();
    localparam int IW = $clog2(N_IN);

    logic                     start;
    logic [N_IN-1:0]          spikes;
    logic                     wr_en;
    logic [IW-1:0]            wr_addr;
    logic signed [W_SIZE-1:0] wr_data;
    logic                     busy;
    logic                     syn_valid;
    logic signed [V_SIZE-1:0] syn_out;

    modport master (
        output start, spikes, wr_en, wr_addr, wr_data,
        input  busy, syn_valid, syn_out
    );

    modport slave (
        input  start, spikes, wr_en, wr_addr, wr_data,
        output busy, syn_valid, syn_out
    );
endinterface

// File: rtl/synapse_accum.sv
// Serial weighted-spike integrator: one input per cycle, saturating after every add,
// result presented as a one-cycle signed current pulse for a LIF neuron.
module synapse_accum #(
    parameter int N_IN   = 8,
    parameter int V_SIZE = 4,
    parameter int W_SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    synapse_accum_if.slave  bus
);
    localparam int IW = $clog2(N_IN);
    localparam logic signed [V_SIZE:0] SAT_MAX = (V_SIZE+1)'((1 << (V_SIZE-1)) - 1);
    localparam logic signed [V_SIZE:0] SAT_MIN = (V_SIZE+1)'(-(1 << (V_SIZE-1)));

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic signed [V_SIZE-1:0] acc_q, acc_d;
    logic [N_IN-1:0]          spikes_q, spikes_d;
    logic                     syn_valid_q, syn_valid_d;
    logic signed [V_SIZE-1:0] syn_out_q, syn_out_d;
    logic signed [W_SIZE-1:0] weight_q [N_IN];
    logic signed [W_SIZE-1:0] weight_d [N_IN];

    logic                     addr_ok;
    logic signed [V_SIZE:0]   term;
    logic signed [V_SIZE:0]   sum_wide;
    logic signed [V_SIZE-1:0] acc_sat;

    // With a power-of-two N_IN every encodable address is a real weight.
    if (N_IN == (1 << IW)) begin : g_full_range
        assign addr_ok = 1'b1;
    end else begin : g_part_range
        assign addr_ok = ({1'b0, bus.wr_addr} < (IW+1)'(N_IN));
    end

    assign term = spikes_q[idx_q]
                ? {{(V_SIZE+1-W_SIZE){weight_q[idx_q][W_SIZE-1]}}, weight_q[idx_q]}
                : '0;
    assign sum_wide = {acc_q[V_SIZE-1], acc_q} + term;

    always_comb begin
        if (sum_wide > SAT_MAX) begin
            acc_sat = SAT_MAX[V_SIZE-1:0];
        end else if (sum_wide < SAT_MIN) begin
            acc_sat = SAT_MIN[V_SIZE-1:0];
        end else begin
            acc_sat = sum_wide[V_SIZE-1:0];
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        spikes_d    = spikes_q;
        syn_valid_d = 1'b0;
        syn_out_d   = '0;
        weight_d    = weight_q;

        if (state_q == IDLE && bus.wr_en && addr_ok) begin
            weight_d[bus.wr_addr] = bus.wr_data;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    spikes_d = bus.spikes;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_sat;
                if (idx_q == IW'(N_IN - 1)) begin
                    state_d     = IDLE;
                    syn_out_d   = acc_sat;
                    syn_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            spikes_q    <= '0;
            syn_valid_q <= 1'b0;
            syn_out_q   <= '0;
            // NOTE: the weight file is reset deliberately; an aborted or fresh run must see zero weights.
            weight_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            spikes_q    <= spikes_d;
            syn_valid_q <= syn_valid_d;
            syn_out_q   <= syn_out_d;
            weight_q    <= weight_d;
        end
    end

    assign bus.busy      = (state_q == ACCUM);
    assign bus.syn_valid = syn_valid_q;
    assign bus.syn_out   = syn_out_q;
endmodule

// File: tb/tb_synapse_accum.sv
// Self-checking bench for synapse_accum: randomized timesteps compared against an
// arithmetic model of the saturating in-order weighted sum.
module tb_synapse_accum;
    localparam int N_IN   = 8;
    localparam int V_SIZE = 4;
    localparam int W_SIZE = 4;
    localparam int IW     = $clog2(N_IN);
    localparam int V_MAX  = (1 << (V_SIZE-1)) - 1;
    localparam int V_MIN  = -(1 << (V_SIZE-1));

    logic clk = 1'b0;
    logic rst = 1'b1;

    synapse_accum_if #(.N_IN(N_IN), .V_SIZE(V_SIZE), .W_SIZE(W_SIZE)) bus ();

    synapse_accum #(.N_IN(N_IN), .V_SIZE(V_SIZE), .W_SIZE(W_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int w_model [N_IN];

    // Reference: clamp after each active input, index order 0..N_IN-1.
    function automatic int model_sum(input logic [N_IN-1:0] spk);
        int acc = 0;
        for (int i = 0; i < N_IN; i++) begin
            if (spk[i]) begin
                acc = acc + w_model[i];
                if (acc > V_MAX) acc = V_MAX;
                if (acc < V_MIN) acc = V_MIN;
            end
        end
        return acc;
    endfunction

    task automatic write_w(input int addr, input int data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = IW'(addr);
        bus.wr_data = W_SIZE'(data);
        @(negedge clk);
        bus.wr_en   = 1'b0;
        w_model[addr] = data;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_IN; i++) w_model[i] = 0;
    endtask

    // Launches one timestep and reports what was observed; cycle c is the cycle after edge t0+c-1.
    task automatic run_ts(input logic [N_IN-1:0] spk, output int busy_cycles,
                          output int valid_at, output int valid_cnt,
                          output int out_val, output int out_after, output int leaks);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.spikes = spk;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.wr_en  = 1'b0;
        bus.spikes = N_IN'($urandom);
        busy_cycles = 0; valid_at = -1; valid_cnt = 0;
        out_val = 0; out_after = 99; leaks = 0;
        for (int c = 1; c <= N_IN + 4; c++) begin
            if (bus.busy) busy_cycles++;
            if (bus.syn_valid) begin
                valid_cnt++;
                if (valid_at < 0) begin
                    valid_at = c;
                    out_val  = int'($signed(bus.syn_out));
                end
            end else begin
                if (bus.syn_out !== '0) leaks++;
                if (valid_at > 0 && c == valid_at + 1) out_after = int'($signed(bus.syn_out));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bc, va, vc, ov, oa, lk;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.syn_valid !== 1'b0 || bus.syn_out !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b valid=%b out=%0d want 0/0/0",
                     bus.busy, bus.syn_valid, bus.syn_out);
        end
        rst = 1'b0;
        clear_model();
        run_ts(8'hFF, bc, va, vc, ov, oa, lk);
        total++;
        if (bc !== N_IN) begin bad++; $display("FAIL reset_busy_len got=%0d want=%0d", bc, N_IN); end
        total++;
        if (va !== N_IN + 1) begin bad++; $display("FAIL reset_valid_time got=%0d want=%0d", va, N_IN + 1); end
        total++;
        if (ov !== 0 || oa !== 0) begin bad++; $display("FAIL reset_cleared_weights got=%0d/%0d want=0/0", ov, oa); end
    endtask

    task automatic test_weighted();
        int bc, va, vc, ov, oa, lk;
        for (int i = 0; i < N_IN; i++) write_w(i, i - 4);
        run_ts(8'b1010_0101, bc, va, vc, ov, oa, lk);
        total++;
        if (ov !== model_sum(8'b1010_0101) || va !== N_IN + 1) begin
            bad++;
            $display("FAIL weighted_sum got=%0d@%0d want=%0d@%0d", ov, va, model_sum(8'b1010_0101), N_IN + 1);
        end
        total++;
        if (vc !== 1 || oa !== 0 || lk !== 0) begin
            bad++;
            $display("FAIL weighted_pulse got cnt=%0d after=%0d leaks=%0d want 1/0/0", vc, oa, lk);
        end
    endtask

    task automatic test_saturation();
        int bc, va, vc, ov, oa, lk;
        for (int i = 0; i < N_IN; i++) write_w(i, (i == 0 || i == 1) ? 7 : (i == 2) ? -8 : 0);
        run_ts(8'h07, bc, va, vc, ov, oa, lk);
        total++;
        if (ov !== -1) begin bad++; $display("FAIL sat_order got=%0d want=%0d", ov, -1); end
        for (int i = 0; i < N_IN; i++) write_w(i, -8);
        run_ts(8'hFF, bc, va, vc, ov, oa, lk);
        total++;
        if (ov !== model_sum(8'hFF)) begin bad++; $display("FAIL sat_negative got=%0d want=%0d", ov, model_sum(8'hFF)); end
    endtask

    task automatic test_random();
        int bc, va, vc, ov, oa, lk, errs;
        logic [N_IN-1:0] spk;
        errs = 0;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N_IN; i++) write_w(i, int'($urandom_range(0, 15)) - 8);
            spk = N_IN'($urandom);
            run_ts(spk, bc, va, vc, ov, oa, lk);
            total++;
            if (ov !== model_sum(spk) || va !== N_IN + 1 || bc !== N_IN || lk !== 0) begin
                bad++; errs++;
                if (errs < 5) $display("FAIL random_run%0d spikes=%h got=%0d@%0d want=%0d@%0d",
                                       r, spk, ov, va, model_sum(spk), N_IN + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bc, va, vc, ov, oa, lk;
        int v1_at, v1_out, v2_at, v2_out, vcnt, old_w2;
        logic [N_IN-1:0] spk1, spk2;
        for (int i = 0; i < N_IN; i++) write_w(i, int'($urandom_range(1, 7)));
        old_w2 = w_model[2];
        spk1 = N_IN'($urandom) | 8'h01;
        spk2 = N_IN'($urandom);
        v1_at = -1; v2_at = -1; v1_out = 0; v2_out = 0; vcnt = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.spikes = spk1;
        @(negedge clk);
        for (int c = 1; c <= 22; c++) begin
            if (bus.syn_valid) begin
                vcnt++;
                if (v1_at < 0) begin v1_at = c; v1_out = int'($signed(bus.syn_out)); end
                else begin v2_at = c; v2_out = int'($signed(bus.syn_out)); end
            end
            bus.start   = (c == 3 || c == 9);
            bus.spikes  = (c == 3) ? '0 : (c == 9) ? spk2 : N_IN'($urandom);
            bus.wr_en   = (c == 4);
            bus.wr_addr = IW'(2);
            bus.wr_data = W_SIZE'(-old_w2);
            @(negedge clk);
        end
        total++;
        if (v1_at !== N_IN + 1 || v1_out !== model_sum(spk1)) begin
            bad++; $display("FAIL busy_start_ignored got=%0d@%0d want=%0d@%0d", v1_out, v1_at, model_sum(spk1), N_IN + 1);
        end
        total++;
        if (v2_at !== 2 * (N_IN + 1) || v2_out !== model_sum(spk2) || vcnt !== 2) begin
            bad++; $display("FAIL back_to_back got=%0d@%0d cnt=%0d want=%0d@%0d cnt=2",
                            v2_out, v2_at, vcnt, model_sum(spk2), 2 * (N_IN + 1));
        end
        run_ts(8'h04, bc, va, vc, ov, oa, lk);
        total++;
        if (ov !== old_w2) begin bad++; $display("FAIL busy_write_ignored got=%0d want=%0d", ov, old_w2); end
    endtask

    task automatic test_mid_reset();
        int bc, va, vc, ov, oa, lk, vcnt, busy_err;
        for (int i = 0; i < N_IN; i++) write_w(i, int'($urandom_range(1, 7)));
        vcnt = 0; busy_err = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.spikes = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (bus.syn_valid) vcnt++;
            if (bus.busy !== (c <= 4)) busy_err++;
            rst = (c == 4);
            @(negedge clk);
        end
        rst = 1'b0;
        total++;
        if (vcnt !== 0 || busy_err !== 0) begin
            bad++; $display("FAIL mid_reset_abort got valid_cnt=%0d busy_err=%0d want 0/0", vcnt, busy_err);
        end
        clear_model();
        run_ts(8'hFF, bc, va, vc, ov, oa, lk);
        total++;
        if (ov !== 0 || va !== N_IN + 1) begin bad++; $display("FAIL mid_reset_weights got=%0d@%0d want=0@%0d", ov, va, N_IN + 1); end
    endtask

    task automatic test_idle_edges();
        int bc, va, vc, ov, oa, lk;
        for (int i = 0; i < N_IN; i++) write_w(i, 0);
        // Write and start on the same edge: the fresh weight must be used.
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = IW'(3);
        bus.wr_data = W_SIZE'(5);
        w_model[3]  = 5;
        run_ts(8'h08, bc, va, vc, ov, oa, lk);
        total++;
        if (ov !== 5) begin bad++; $display("FAIL write_with_start got=%0d want=5", ov); end
        // With N_IN=8 a 3-bit address cannot exceed the file; check all entries read back instead.
        for (int i = 0; i < N_IN; i++) begin
            run_ts(N_IN'(1) << i, bc, va, vc, ov, oa, lk);
            total++;
            if (ov !== w_model[i]) begin bad++; $display("FAIL readback_w%0d got=%0d want=%0d", i, ov, w_model[i]); end
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.spikes  = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        clear_model();
        test_reset();
        test_weighted();
        test_saturation();
        test_random();
        test_back_to_back();
        test_mid_reset();
        test_idle_edges();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
